led_sequencer: RTL

Parametrised successor to the single-button LED colour cycler. It drives a WIDTH-bit colour code through a configurable range [FIRST, LAST] under control of a debounced push button. It supports up, down, bounce and freeze modes, a hold-to-run or one-step-per-press policy, and a prescaler on the hold-to-run step rate. It sits between the board button input and the RGB LED driver, and exposes a wrap pulse for downstream effects logic.

---
 rtl/led_sequencer_if.sv | 21 ++
 rtl/led_sequencer.sv | 140 ++++++++++++++
 2 files changed

// File: rtl/led_sequencer_if.sv
// rtl/led_sequencer_if.sv - button/mode controls in, colour/wrap/dir status out
interface led_sequencer_if #(
    parameter int WIDTH = 3
);
    logic             button;
    logic [1:0]       mode;
    logic             step_mode;
    logic [WIDTH-1:0] colour;
    logic             wrap;
    logic             dir;

    modport master (
        output button, mode, step_mode,
        input  colour, wrap, dir
    );

    modport slave (
        input  button, mode, step_mode,
        output colour, wrap, dir
    );
endinterface

// File: rtl/led_sequencer.sv
// rtl/led_sequencer.sv - debounced push-button colour sequencer with up/down/bounce/freeze modes
module led_sequencer #(
    parameter int WIDTH    = 3,
    parameter int FIRST    = 1,
    parameter int LAST     = 6,
    parameter int DEBOUNCE = 4,
    parameter int PRESCALE = 1
) (
    input  logic          clk,
    input  logic          rst,
    led_sequencer_if.slave bus
);
    localparam int DBW = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
    localparam int PSW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [WIDTH-1:0] FIRST_C = WIDTH'(FIRST);
    localparam logic [WIDTH-1:0] LAST_C  = WIDTH'(LAST);
    localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);
    localparam logic [DBW-1:0]   DB_MAX  = DBW'(DEBOUNCE - 1);
    localparam logic [PSW-1:0]   PS_MAX  = PSW'(PRESCALE - 1);

    logic             s1, s2;
    logic             btn_db, btn_db_prev;
    logic [DBW-1:0]   db_cnt;
    logic [PSW-1:0]   ps_cnt;
    logic [WIDTH-1:0] colour_q;
    logic             wrap_q, dir_q;

    logic             step_req;
    logic             out_of_range;
    logic [WIDTH-1:0] nxt_colour;
    logic             nxt_wrap, nxt_dir;

    assign bus.colour = colour_q;
    assign bus.wrap   = wrap_q;
    assign bus.dir    = dir_q;

    assign out_of_range = (colour_q < FIRST_C) || (colour_q > LAST_C);

    always_comb begin
        step_req = 1'b0;
        if (bus.step_mode)
            step_req = btn_db & ~btn_db_prev;
        else
            step_req = btn_db && (ps_cnt == PS_MAX);
    end

    // Sequence end points are handled explicitly so the code never wraps modulo 2^WIDTH.
    always_comb begin
        nxt_colour = colour_q;
        nxt_wrap   = 1'b0;
        nxt_dir    = dir_q;
        case (bus.mode)
            2'b00: begin
                if (colour_q == LAST_C) begin
                    nxt_colour = FIRST_C;
                    nxt_wrap   = 1'b1;
                end else begin
                    nxt_colour = colour_q + ONE;
                end
            end
            2'b01: begin
                if (colour_q == FIRST_C) begin
                    nxt_colour = LAST_C;
                    nxt_wrap   = 1'b1;
                end else begin
                    nxt_colour = colour_q - ONE;
                end
            end
            2'b10: begin
                if (!dir_q) begin
                    if (colour_q == LAST_C) begin
                        nxt_colour = LAST_C - ONE;
                        nxt_dir    = 1'b1;
                        nxt_wrap   = 1'b1;
                    end else begin
                        nxt_colour = colour_q + ONE;
                    end
                end else begin
                    if (colour_q == FIRST_C) begin
                        nxt_colour = FIRST_C + ONE;
                        nxt_dir    = 1'b0;
                        nxt_wrap   = 1'b1;
                    end else begin
                        nxt_colour = colour_q - ONE;
                    end
                end
            end
            default: begin
                nxt_colour = colour_q;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1          <= 1'b0;
            s2          <= 1'b0;
            btn_db      <= 1'b0;
            btn_db_prev <= 1'b0;
            db_cnt      <= '0;
            ps_cnt      <= '0;
            colour_q    <= FIRST_C;
            wrap_q      <= 1'b0;
            dir_q       <= 1'b0;
        end else begin
            s1          <= bus.button;
            s2          <= s1;
            btn_db_prev <= btn_db;

            if (s2 != btn_db) begin
                if (db_cnt == DB_MAX) begin
                    btn_db <= s2;
                    db_cnt <= '0;
                end else begin
                    db_cnt <= db_cnt + 1'b1;
                end
            end else begin
                db_cnt <= '0;
            end

            if (!bus.step_mode && btn_db)
                ps_cnt <= (ps_cnt == PS_MAX) ? '0 : ps_cnt + 1'b1;
            else
                ps_cnt <= '0;

            if (out_of_range) begin
                colour_q <= FIRST_C;
                wrap_q   <= 1'b0;
                dir_q    <= 1'b0;
            end else if (step_req) begin
                colour_q <= nxt_colour;
                wrap_q   <= nxt_wrap;
                dir_q    <= (bus.mode == 2'b10) ? nxt_dir : 1'b0;
            end else begin
                wrap_q   <= 1'b0;
                dir_q    <= (bus.mode == 2'b10) ? dir_q : 1'b0;
            end
        end
    end
endmodule
